banked_regfile: RTL and testbench
=================================

# banked_regfile

Mode-banked general-purpose register file for the ARM32 core: 31 physical 32-bit registers addressed by 4-bit architectural indices, remapped per processor mode. It holds the current mode register and supports a user-bank override for user-register transfers. It sits between decode (read ports) and writeback (write port), with registered read data feeding the execute stage.

## Interface
Parameters:
- `DATA_W`, 32: register width.
- `NREAD`, 2: number of read ports, 1..3.
- `RESET_MODE`, 5'b10011: mode value loaded on reset (SVC).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_en`  in  NREAD  per-port read request.
- `rd_addr`  in  4*NREAD  architectural index per port; port i at bits [4i+3:4i].
- `rd_user`  in  NREAD  per-port: map as USR mode regardless of current mode.
- `rd_data`  out  DATA_W*NREAD  registered read data, port i at [DATA_W*i +: DATA_W].
- `rd_valid`  out  NREAD  high one cycle after the accepted `rd_en`.
- `wr_en`  in  1  write request.
- `wr_addr`  in  4  architectural write index.
- `wr_user`  in  1  map write as USR mode.
- `wr_data`  in  DATA_W  write data.
- `mode_wr`  in  1  load `mode_in` into the mode register.
- `mode_in`  in  5  new mode (CPSR[4:0]).
- `cur_mode`  out  5  current mode register.
- `mode_err`  out  1  one-cycle pulse: last `mode_wr` carried an illegal encoding.

## Operation
- Legal modes: USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111. Any other value on `mode_wr`: mode register unchanged, `mode_err` pulses the next cycle.
- Physical map, with the effective mode equal to USR when the user flag is set, else `cur_mode`:
  - Phys 0-15: default map.
  - FIQ: R8-R14 → phys 16-22.
  - SVC: R13/R14 → 23/24.
  - ABT: R13/R14 → 25/26.
  - IRQ: R13/R14 → 27/28.
  - UND: R13/R14 → 29/30.
  - USR/SYS and all unlisted indices → phys = index.
  - R15 is always phys 15.
- Write: when `wr_en` is high, phys[map(`wr_addr`)] ← `wr_data` at the edge.
- Read: when `rd_en[i]` is high, `rd_data[i]` ← phys[map(`rd_addr[i]`)] at the edge and `rd_valid[i]` ← 1. When `rd_en[i]` is low, `rd_valid[i]` ← 0 and `rd_data[i]` holds its value.
- Mapping for reads and writes in a cycle uses the mode register value *before* that edge. A `mode_wr` takes effect for accesses in the following cycle.
- Read and write to the same physical register in one cycle: behaviour per Configuration. Read and write to different physical registers are independent.
- Multiple read ports may hit the same register. Each port returns identical data.

## Timing
- Read latency: 1 cycle (addr at edge N, data and valid after edge N).
- Write visible to a read issued in cycle N+1 without bypass.
- Mode write at edge N: `cur_mode` updates after edge N. Accesses in cycle N+1 use the new map.
- `mode_err` is high exactly in the cycle after an illegal `mode_wr`.
- Reset, including mid-operation:
  - All 31 registers ← 0.
  - `rd_data` ← 0, `rd_valid` ← 0.
  - `cur_mode` ← `RESET_MODE`, `mode_err` ← 0.
  - Writes, reads and mode writes presented in the reset cycle are discarded.

## Configuration
- `REGFILE_BYPASS_EN` defined: a same-cycle write to the physical register being read forwards `wr_data` into `rd_data` (write-first).
- Undefined: the read returns the pre-write contents (read-first). The new value is visible from the next read.
- The physical compare uses the respective mapped indices. Example: a write to R13 in SVC and a user-flag read of R13 do not collide.

## Test plan
- Reset, then read R0..R15 in SVC → all `rd_data` = 0, `cur_mode` = 10011, each `rd_valid` one cycle after its `rd_en`.
- FIQ banking:
  - Sequence: write R8 = 0xAAAA0008 in USR; switch to FIQ; write R8 = 0xFFFF0008; switch to USR; read R8.
  - Required: USR read returns 0xAAAA0008. In FIQ, a read of R8 returns 0xFFFF0008.
- SVC, user override: write R13 = 0x1000; write R13 = 0x2000 with `wr_user`=1. Read R13 → 0x1000; read R13 with `rd_user`=1 → 0x2000.
- Same-cycle write/read of R5 = 0x55, old value 0x0:
  - Bypass build: `rd_data` = 0x55.
  - Non-bypass build: `rd_data` = 0x0; the next read returns 0x55.
- `mode_wr` = 10101 (illegal) from IRQ → `cur_mode` stays 10010, `mode_err` high for exactly one cycle. In the same cycle, a write of R14 = 0x77 lands in phys 28.
- Mode switch IRQ→UND with a simultaneous write R13 = 0x33 → IRQ R13 = 0x33, UND R13 unchanged (0). Assert `rst` mid-sequence → all reads 0, `cur_mode` = 10011.

Source files
------------

// File: rtl/banked_regfile.sv
// banked_regfile: mode-banked ARM32 register file, 31 physical x DATA_W registers.
// Architectural indices are remapped per processor mode (or forced to USR by the
// per-access user flag). Read data is registered; writes land at the clock edge.
// Optional feature macro: REGFILE_BYPASS_EN selects write-first forwarding on a
// same-cycle read/write of one physical register; when undefined the read sees
// the pre-write contents (read-first).
module banked_regfile #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NREAD      = 2,
  parameter logic [4:0]  RESET_MODE = 5'b10011
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD-1:0]         rd_en,
  input  logic [4*NREAD-1:0]       rd_addr,
  input  logic [NREAD-1:0]         rd_user,
  output logic [DATA_W*NREAD-1:0]  rd_data,
  output logic [NREAD-1:0]         rd_valid,
  input  logic                     wr_en,
  input  logic [3:0]               wr_addr,
  input  logic                     wr_user,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     mode_wr,
  input  logic [4:0]               mode_in,
  output logic [4:0]               cur_mode,
  output logic                     mode_err
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned PHYS_W = 5;
  localparam int unsigned MODE_W = 5;
  localparam int unsigned NPHYS  = 31;

  localparam logic [MODE_W-1:0] MODE_USR = 5'b10000;
  localparam logic [MODE_W-1:0] MODE_FIQ = 5'b10001;
  localparam logic [MODE_W-1:0] MODE_IRQ = 5'b10010;
  localparam logic [MODE_W-1:0] MODE_SVC = 5'b10011;
  localparam logic [MODE_W-1:0] MODE_ABT = 5'b10111;
  localparam logic [MODE_W-1:0] MODE_UND = 5'b11011;
  localparam logic [MODE_W-1:0] MODE_SYS = 5'b11111;

  // True for the seven architecturally defined mode encodings.
  function automatic logic mode_legal(input logic [MODE_W-1:0] m);
    logic ok;
    ok = 1'b0;
    case (m)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Banked R13/R14 pair: the two registers sit at base and base+1.
  function automatic logic [PHYS_W-1:0] pair_map(input logic [IDX_W-1:0] idx,
                                                 input logic [PHYS_W-1:0] base);
    logic [PHYS_W-1:0] phys;
    phys = PHYS_W'(idx);
    if (idx == 4'd13)      phys = base;
    else if (idx == 4'd14) phys = base + 5'd1;
    return phys;
  endfunction

  // Architectural index plus effective mode to physical register number.
  function automatic logic [PHYS_W-1:0] map_phys(input logic [IDX_W-1:0]  idx,
                                                 input logic [MODE_W-1:0] mode);
    logic [PHYS_W-1:0] phys;
    phys = PHYS_W'(idx);
    case (mode)
      MODE_FIQ: if (idx >= 4'd8 && idx <= 4'd14) phys = PHYS_W'(idx) + 5'd8;
      MODE_SVC: phys = pair_map(idx, 5'd23);
      MODE_ABT: phys = pair_map(idx, 5'd25);
      MODE_IRQ: phys = pair_map(idx, 5'd27);
      MODE_UND: phys = pair_map(idx, 5'd29);
      default:  phys = PHYS_W'(idx);
    endcase
    return phys;
  endfunction

  logic [DATA_W-1:0] regs_q [NPHYS];
  logic [DATA_W-1:0] regs_d [NPHYS];
  logic [DATA_W-1:0] rd_data_q [NREAD];
  logic [DATA_W-1:0] rd_data_d [NREAD];
  logic [NREAD-1:0]  rd_valid_q, rd_valid_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              err_q, err_d;
  logic [PHYS_W-1:0] wr_phys_c;

  // Physical target of the write port, using the pre-edge mode.
  always_comb begin
    wr_phys_c = map_phys(wr_addr, wr_user ? MODE_USR : mode_q);
  end

  // Register array next state: single write port.
  always_comb begin
    for (int k = 0; k < NPHYS; k++) regs_d[k] = regs_q[k];
    if (wr_en) regs_d[wr_phys_c] = wr_data;
  end

  // Read ports: capture on request, hold data otherwise.
  always_comb begin
    logic [PHYS_W-1:0] rph;
    rph = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_data_d[i]  = rd_data_q[i];
      rd_valid_d[i] = 1'b0;
      if (rd_en[i]) begin
        rph = map_phys(rd_addr[IDX_W*i +: IDX_W], rd_user[i] ? MODE_USR : mode_q);
        rd_valid_d[i] = 1'b1;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_phys_c == rph)) rd_data_d[i] = wr_data;
        else                             rd_data_d[i] = regs_q[rph];
`else
        rd_data_d[i] = regs_q[rph];
`endif
      end
    end
  end

  // Mode register: only legal encodings are accepted; illegal ones flag an error.
  always_comb begin
    mode_d = mode_q;
    err_d  = 1'b0;
    if (mode_wr) begin
      if (mode_legal(mode_in)) mode_d = mode_in;
      else                     err_d  = 1'b1;
    end
  end

  // State registers with synchronous reset that discards same-cycle requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NPHYS; k++) regs_q[k] <= '0;
      for (int i = 0; i < NREAD; i++) rd_data_q[i] <= '0;
      rd_valid_q <= '0;
      mode_q     <= RESET_MODE;
      err_q      <= 1'b0;
    end else begin
      for (int k = 0; k < NPHYS; k++) regs_q[k] <= regs_d[k];
      for (int i = 0; i < NREAD; i++) rd_data_q[i] <= rd_data_d[i];
      rd_valid_q <= rd_valid_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
    end
  end

  // Flatten registered read data onto the output bus.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREAD; i++) rd_data[DATA_W*i +: DATA_W] = rd_data_q[i];
  end

  assign rd_valid = rd_valid_q;
  assign cur_mode = mode_q;
  assign mode_err = err_q;

endmodule

// File: tb/tb_banked_regfile.sv
// Self-checking bench for banked_regfile: directed vectors, a per-cycle
// behavioural model comparison, and literal expectations from the test plan.
module tb_banked_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2;
  localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010,
                         SVC = 5'b10011, ABT = 5'b10111, UND = 5'b11011,
                         SYS = 5'b11111;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     rd_en;
  logic [4*NR-1:0]   rd_addr;
  logic [NR-1:0]     rd_user;
  logic [DW*NR-1:0]  rd_data;
  logic [NR-1:0]     rd_valid;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic              wr_user;
  logic [DW-1:0]     wr_data;
  logic              mode_wr;
  logic [4:0]        mode_in;
  logic [4:0]        cur_mode;
  logic              mode_err;

  int n_checks = 0;
  int n_fail   = 0;

  banked_regfile #(.DATA_W(DW), .NREAD(NR), .RESET_MODE(5'b10011)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_user(rd_user),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_user(wr_user), .wr_data(wr_data),
    .mode_wr(mode_wr), .mode_in(mode_in),
    .cur_mode(cur_mode), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_regs [31];
  logic [DW-1:0] m_data [NR];
  logic [NR-1:0] m_valid;
  logic [4:0]    m_mode;
  logic          m_err;
  logic          m_live = 1'b0;

  // Register-bank view: which physical slot an index lands in for a mode.
  function automatic int model_phys(input int idx, input logic [4:0] mode);
    int base;
    if (idx == 15) return 15;
    if (mode == FIQ && idx >= 8) return idx + 8;
    if (idx < 13) return idx;
    case (mode)
      SVC: base = 23;
      ABT: base = 25;
      IRQ: base = 27;
      UND: base = 29;
      default: return idx;
    endcase
    return base + (idx - 13);
  endfunction

  function automatic bit model_legal(input logic [4:0] m);
    return m inside {USR, FIQ, IRQ, SVC, ABT, UND, SYS};
  endfunction

  always @(posedge clk) begin
    int ph, wph;
    if (rst) begin
      for (int k = 0; k < 31; k++) m_regs[k] = '0;
      for (int p = 0; p < NR; p++) m_data[p] = '0;
      m_valid = '0;
      m_mode  = SVC;
      m_err   = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      wph = model_phys(int'(wr_addr), wr_user ? USR : m_mode);
      for (int p = 0; p < NR; p++) begin
        m_valid[p] = rd_en[p];
        if (rd_en[p]) begin
          ph = model_phys(int'(rd_addr[4*p +: 4]), rd_user[p] ? USR : m_mode);
          m_data[p] = m_regs[ph];
`ifdef REGFILE_BYPASS_EN
          if (wr_en && wph == ph) m_data[p] = wr_data;
`endif
        end
      end
      if (wr_en) m_regs[wph] = wr_data;
      m_err = mode_wr && !model_legal(mode_in);
      if (mode_wr && model_legal(mode_in)) m_mode = mode_in;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_live) begin
      for (int p = 0; p < NR; p++) begin
        check($sformatf("model rd_valid[%0d]", p), 32'(rd_valid[p]), 32'(m_valid[p]));
        check($sformatf("model rd_data[%0d]", p), rd_data[DW*p +: DW], m_data[p]);
      end
      check("model cur_mode", 32'(cur_mode), 32'(m_mode));
      check("model mode_err", 32'(mode_err), 32'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    rd_en = '0; rd_addr = '0; rd_user = '0;
    wr_en = 1'b0; wr_addr = '0; wr_user = 1'b0; wr_data = '0;
    mode_wr = 1'b0; mode_in = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic set_write(input logic [3:0] a, input logic [31:0] d, input logic u);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_user = u;
  endtask

  task automatic set_read(input int p, input logic [3:0] a, input logic u);
    rd_en[p] = 1'b1; rd_addr[4*p +: 4] = a; rd_user[p] = u;
  endtask

  task automatic do_mode(input logic [4:0] m);
    mode_wr = 1'b1; mode_in = m;
    tick();
  endtask

  function automatic logic [31:0] port(input int p);
    return rd_data[DW*p +: DW];
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset cur_mode", 32'(cur_mode), 32'h13);
    check("reset rd_valid", 32'(rd_valid), 32'h0);
    check("reset mode_err", 32'(mode_err), 32'h0);

    // All sixteen indices read zero in SVC after reset.
    for (int i = 0; i < 16; i++) begin
      set_read(0, 4'(i), 1'b0);
      set_read(1, 4'(15 - i), 1'b0);
      tick();
      check("post-reset r0 data", port(0), 32'h0);
      check("post-reset r1 data", port(1), 32'h0);
      check("post-reset valid", 32'(rd_valid), 32'h3);
    end
    tick();
    check("valid drops when idle", 32'(rd_valid), 32'h0);

    // FIQ banking of R8.
    do_mode(USR);
    set_write(4'd8, 32'hAAAA0008, 1'b0); tick();
    do_mode(FIQ);
    set_write(4'd8, 32'hFFFF0008, 1'b0); tick();
    set_read(0, 4'd8, 1'b0); tick();
    check("fiq R8", port(0), 32'hFFFF0008);
    do_mode(USR);
    set_read(0, 4'd8, 1'b0); tick();
    check("usr R8", port(0), 32'hAAAA0008);

    // SVC R13 with user override.
    do_mode(SVC);
    set_write(4'd13, 32'h1000, 1'b0); tick();
    set_write(4'd13, 32'h2000, 1'b1); tick();
    set_read(0, 4'd13, 1'b0);
    set_read(1, 4'd13, 1'b1);
    tick();
    check("svc R13", port(0), 32'h1000);
    check("user R13 from svc", port(1), 32'h2000);

    // Same-cycle write/read of R5.
    set_write(4'd5, 32'h55, 1'b0);
    set_read(0, 4'd5, 1'b0);
    set_read(1, 4'd5, 1'b0);
    tick();
`ifdef REGFILE_BYPASS_EN
    check("same-cycle R5", port(0), 32'h55);
`else
    check("same-cycle R5", port(0), 32'h0);
`endif
    check("same-cycle both ports agree", port(1), port(0) === port(1) ? port(0) : 32'hDEAD_BEEF);
    set_read(0, 4'd5, 1'b0); tick();
    check("R5 next read", port(0), 32'h55);

    // Colliding indices in different banks are independent.
    set_write(4'd13, 32'h3000, 1'b0);
    set_read(0, 4'd13, 1'b1);
    tick();
    check("svc write vs user read", port(0), 32'h2000);

    // Illegal mode write from IRQ with a write of R14.
    do_mode(IRQ);
    mode_wr = 1'b1; mode_in = 5'b10101;
    set_write(4'd14, 32'h77, 1'b0);
    tick();
    check("illegal mode keeps IRQ", 32'(cur_mode), 32'h12);
    check("mode_err pulse", 32'(mode_err), 32'h1);
    set_read(0, 4'd14, 1'b0);
    set_read(1, 4'd14, 1'b1);
    tick();
    check("mode_err one cycle", 32'(mode_err), 32'h0);
    check("irq R14 (phys 28)", port(0), 32'h77);
    check("usr R14 untouched", port(1), 32'h0);

    // IRQ -> UND switch with simultaneous write of R13.
    mode_wr = 1'b1; mode_in = UND;
    set_write(4'd13, 32'h33, 1'b0);
    tick();
    check("mode now UND", 32'(cur_mode), 32'h1B);
    set_read(0, 4'd13, 1'b0); tick();
    check("und R13", port(0), 32'h0);
    do_mode(IRQ);
    set_read(0, 4'd13, 1'b0); tick();
    check("irq R13", port(0), 32'h33);

    // Mid-sequence reset discards same-cycle requests.
    set_read(0, 4'd13, 1'b0);
    tick();
    rst = 1'b1;
    set_write(4'd0, 32'h99, 1'b0);
    set_read(0, 4'd14, 1'b0);
    mode_wr = 1'b1; mode_in = FIQ;
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    check("rst cur_mode", 32'(cur_mode), 32'h13);
    check("rst rd_valid", 32'(rd_valid), 32'h0);
    check("rst rd_data", port(0), 32'h0);
    set_read(0, 4'd0, 1'b0);
    set_read(1, 4'd13, 1'b0);
    tick();
    check("rst R0", port(0), 32'h0);
    check("rst svc R13", port(1), 32'h0);
    do_mode(IRQ);
    set_read(0, 4'd13, 1'b0);
    set_read(1, 4'd14, 1'b0);
    tick();
    check("rst irq R13", port(0), 32'h0);
    check("rst irq R14", port(1), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
